// File: rtl/button_conditioner_if.sv
// Button conditioner signal bundle: raw contact in, debounced level and event pulses out.
//   BTN_RAW     raw asynchronous push-button, 1 = pressed
//   BTN_LEVEL   debounced button state
//   BTN_PRESS   one-cycle pulse on accepted press
//   BTN_RELEASE one-cycle pulse on accepted release
//   BTN_LONG    one-cycle pulse when a hold reaches the long-press time
interface button_conditioner_if;
   logic BTN_RAW;
   logic BTN_LEVEL;
   logic BTN_PRESS;
   logic BTN_RELEASE;
   logic BTN_LONG;

   // Conditioner side
   modport master (
      input  BTN_RAW,
      output BTN_LEVEL,
      output BTN_PRESS,
      output BTN_RELEASE,
      output BTN_LONG
   );

   // Button / consumer side
   modport slave (
      output BTN_RAW,
      input  BTN_LEVEL,
      input  BTN_PRESS,
      input  BTN_RELEASE,
      input  BTN_LONG
   );
endinterface

// File: rtl/button_conditioner.sv
// Synchronises and debounces the push-button, producing a clean level plus
// press / release / long-press pulses.
//   CLK  system clock
//   RST  synchronous active-high reset
//   btn  button_conditioner_if.master (BTN_RAW in; BTN_LEVEL, BTN_PRESS,
//        BTN_RELEASE, BTN_LONG out, all registered)
module button_conditioner #(
   parameter int unsigned CLK_FREQ    = 12_000_000,
   parameter int unsigned DEBOUNCE_MS = 20,
   parameter int unsigned LONG_MS     = 1000
) (
   input  logic                 CLK,
   input  logic                 RST,
   button_conditioner_if.master btn
);

   localparam int unsigned DB_CYCLES   = CLK_FREQ / 1000 * DEBOUNCE_MS;
   localparam int unsigned LONG_CYCLES = CLK_FREQ / 1000 * LONG_MS;
   localparam int unsigned DB_W        = $clog2(DB_CYCLES + 1);
   localparam int unsigned HOLD_W      = $clog2(LONG_CYCLES + 1);

   typedef enum logic [1:0] {
      IDLE,
      ARM_PRESS,
      PRESSED,
      ARM_RELEASE
   } state_t;

   state_t              state_q, state_nxt;
   logic [DB_W-1:0]     cnt_q, cnt_nxt;
   logic [HOLD_W-1:0]   hold_q, hold_nxt;
   logic                level_q, level_nxt;
   logic                press_q, press_nxt;
   logic                release_q, release_nxt;
   logic                long_q, long_nxt;
   logic                meta_q, sync_q;

   // Two-stage synchroniser; only sync_q is used by the FSM
   always_ff @(posedge CLK) begin
      if (RST) begin
         meta_q <= 1'b0;
         sync_q <= 1'b0;
      end else begin
         meta_q <= btn.BTN_RAW;
         sync_q <= meta_q;
      end
   end

   // State, counters and registered outputs
   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q   <= IDLE;
         cnt_q     <= '0;
         hold_q    <= '0;
         level_q   <= 1'b0;
         press_q   <= 1'b0;
         release_q <= 1'b0;
         long_q    <= 1'b0;
      end else begin
         state_q   <= state_nxt;
         cnt_q     <= cnt_nxt;
         hold_q    <= hold_nxt;
         level_q   <= level_nxt;
         press_q   <= press_nxt;
         release_q <= release_nxt;
         long_q    <= long_nxt;
      end
   end

   // Next-state and output decode
   always_comb begin
      state_nxt   = state_q;
      cnt_nxt     = cnt_q;
      hold_nxt    = hold_q;
      level_nxt   = level_q;
      press_nxt   = 1'b0;
      release_nxt = 1'b0;
      long_nxt    = 1'b0;

      // Hold time keeps running through release bounce, saturating so the long pulse fires once
      if (state_q == PRESSED || state_q == ARM_RELEASE) begin
         if (hold_q != HOLD_W'(LONG_CYCLES))
            hold_nxt = hold_q + HOLD_W'(1);
         if (hold_q == HOLD_W'(LONG_CYCLES - 1))
            long_nxt = 1'b1;
      end

      case (state_q)
         IDLE: begin
            level_nxt = 1'b0;
            if (sync_q) begin
               state_nxt = ARM_PRESS;
               cnt_nxt   = DB_W'(1);
            end
         end
         ARM_PRESS: begin
            if (!sync_q) begin
               state_nxt = IDLE;
            end else if (cnt_q == DB_W'(DB_CYCLES - 1)) begin
               state_nxt = PRESSED;
               level_nxt = 1'b1;
               press_nxt = 1'b1;
               hold_nxt  = '0;
            end else begin
               cnt_nxt = cnt_q + DB_W'(1);
            end
         end
         PRESSED: begin
            if (!sync_q) begin
               state_nxt = ARM_RELEASE;
               cnt_nxt   = DB_W'(1);
            end
         end
         ARM_RELEASE: begin
            if (sync_q) begin
               state_nxt = PRESSED;
            end else if (cnt_q == DB_W'(DB_CYCLES - 1)) begin
               state_nxt   = IDLE;
               level_nxt   = 1'b0;
               release_nxt = 1'b1;
            end else begin
               cnt_nxt = cnt_q + DB_W'(1);
            end
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   assign btn.BTN_LEVEL   = level_q;
   assign btn.BTN_PRESS   = press_q;
   assign btn.BTN_RELEASE = release_q;
   assign btn.BTN_LONG    = long_q;

endmodule

// File: tb/tb_button_conditioner.sv
// Self-checking bench for button_conditioner with DB_CYCLES=4, LONG_CYCLES=20.
module tb_button_conditioner;

   localparam int DB   = 4;
   localparam int LONG = 20;

   logic CLK = 1'b0;
   logic RST = 1'b1;

   always #5 CLK = ~CLK;

   button_conditioner_if ifc ();

   button_conditioner #(
      .CLK_FREQ    (1000),
      .DEBOUNCE_MS (4),
      .LONG_MS     (20)
   ) dut (
      .CLK (CLK),
      .RST (RST),
      .btn (ifc)
   );

   int n_chk  = 0;
   int n_pass = 0;

   // Reference model: two-edge sampling delay, then the level flips once DB
   // consecutive samples disagree with it; long pulse DB-independent, counted
   // in edges since the accepted press while the level is high.
   bit dly0 = 1'b0, dly1 = 1'b0;
   bit m_s, m_was;
   bit m_level = 1'b0;
   bit m_press = 1'b0, m_rel = 1'b0, m_long = 1'b0;
   int run = 0;
   int age = 0;
   bit long_done = 1'b1;

   always @(posedge CLK) begin
      m_press = 1'b0;
      m_rel   = 1'b0;
      m_long  = 1'b0;
      if (RST) begin
         dly0      = 1'b0;
         dly1      = 1'b0;
         m_level   = 1'b0;
         run       = 0;
         age       = 0;
         long_done = 1'b1;
      end else begin
         m_s   = dly1;
         dly1  = dly0;
         dly0  = ifc.BTN_RAW;
         m_was = m_level;
         if (m_was) begin
            age++;
            if (age == LONG && !long_done) begin
               m_long    = 1'b1;
               long_done = 1'b1;
            end
         end
         if (m_s == m_level) begin
            run = 0;
         end else begin
            run++;
            if (run == DB) begin
               run     = 0;
               m_level = !m_level;
               if (m_level) begin
                  m_press   = 1'b1;
                  age       = 0;
                  long_done = 1'b0;
               end else begin
                  m_rel = 1'b1;
               end
            end
         end
      end
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp)
         n_pass++;
      else
         $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
   endtask

   task automatic check_model();
      check("level",   32'(ifc.BTN_LEVEL),   32'(m_level));
      check("press",   32'(ifc.BTN_PRESS),   32'(m_press));
      check("release", 32'(ifc.BTN_RELEASE), 32'(m_rel));
      check("long",    32'(ifc.BTN_LONG),    32'(m_long));
      check("excl", 32'(ifc.BTN_PRESS & (ifc.BTN_RELEASE | ifc.BTN_LONG)), 32'(0));
   endtask

   // Apply inputs at the falling edge, let one rising edge pass, sample at the next falling edge
   task automatic tick(input logic raw, input logic rst_v);
      ifc.BTN_RAW = raw;
      RST         = rst_v;
      @(posedge CLK);
      @(negedge CLK);
      check_model();
   endtask

   int press_at, long_at, long_cnt, rel_cnt;
   int seg_len;
   logic seg_v;

   initial begin
      ifc.BTN_RAW = 1'b0;
      @(negedge CLK);

      // Reset held with the button pressed: everything stays low
      for (int i = 0; i < 3; i++) begin
         tick(1'b1, 1'b1);
         check("rst_out", 32'({ifc.BTN_LEVEL, ifc.BTN_PRESS, ifc.BTN_RELEASE, ifc.BTN_LONG}), 32'(0));
      end

      // Held button detected as a press on the 6th edge after reset falls
      for (int k = 1; k <= 10; k++) begin
         tick(1'b1, 1'b0);
         check("press_lat", 32'(ifc.BTN_PRESS), 32'(k == 6));
         check("level_lat", 32'(ifc.BTN_LEVEL), 32'(k >= 6));
      end

      // Release with bounce: 0,0,1 then held low
      tick(1'b0, 1'b0);
      tick(1'b0, 1'b0);
      tick(1'b1, 1'b0);
      for (int k = 1; k <= 8; k++) begin
         tick(1'b0, 1'b0);
         check("rel_lat",   32'(ifc.BTN_RELEASE), 32'(k == 6));
         check("rel_level", 32'(ifc.BTN_LEVEL),   32'(k < 6));
      end

      // Bouncing press never qualifies
      for (int i = 0; i < 40; i++) begin
         tick(1'((i % 4) != 3), 1'b0);
         check("bounce_lvl", 32'(ifc.BTN_LEVEL), 32'(0));
         check("bounce_prs", 32'(ifc.BTN_PRESS), 32'(0));
      end
      for (int k = 1; k <= 8; k++) begin
         tick(1'b1, 1'b0);
         check("bounce_then_press", 32'(ifc.BTN_PRESS), 32'(k == 6));
      end
      for (int k = 1; k <= 10; k++) tick(1'b0, 1'b0);

      // Long press: exactly one long pulse LONG edges after the press
      press_at = -1; long_at = -1; long_cnt = 0; rel_cnt = 0;
      for (int k = 1; k <= 46; k++) begin
         tick(1'b1, 1'b0);
         if (ifc.BTN_PRESS) press_at = k;
         if (ifc.BTN_LONG) begin
            long_cnt++;
            long_at = k;
         end
      end
      check("long_press_at", 32'(press_at), 32'(6));
      check("long_count",    32'(long_cnt), 32'(1));
      check("long_at",       32'(long_at),  32'(26));
      for (int k = 1; k <= 10; k++) begin
         tick(1'b0, 1'b0);
         if (ifc.BTN_RELEASE) rel_cnt++;
      end
      check("long_release", 32'(rel_cnt), 32'(1));

      // Mid-press reset: level drops, no release, held button redetected
      for (int k = 1; k <= 8; k++) tick(1'b1, 1'b0);
      check("mid_pre_level", 32'(ifc.BTN_LEVEL), 32'(1));
      tick(1'b1, 1'b1);
      check("mid_rst_level", 32'(ifc.BTN_LEVEL),   32'(0));
      check("mid_rst_rel",   32'(ifc.BTN_RELEASE), 32'(0));
      for (int k = 1; k <= 8; k++) begin
         tick(1'b1, 1'b0);
         check("mid_redetect", 32'(ifc.BTN_PRESS),   32'(k == 6));
         check("mid_no_rel",   32'(ifc.BTN_RELEASE), 32'(0));
      end

      // Random runs of bouncing and held levels with occasional resets
      for (int s = 0; s < 250; s++) begin
         seg_v = 1'($urandom_range(0, 1));
         if ($urandom_range(0, 7) == 0)
            seg_len = int'($urandom_range(20, 40));
         else
            seg_len = int'($urandom_range(1, 8));
         if ($urandom_range(0, 39) == 0)
            tick(seg_v, 1'b1);
         for (int j = 0; j < seg_len; j++)
            tick(seg_v, 1'b0);
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

// File: doc/button_conditioner.md
# button_conditioner

Conditions the raw Alhambra II push-button before it reaches the 8-LED binary counter, whose BTN input clears the count while high. The block synchronises the asynchronous contact to CLK and rejects contact bounce. It produces a clean level on BTN_LEVEL, which drives the counter's BTN directly. It also produces single-cycle press, release and long-press pulses for other consumers.

## Interface
- CLK_FREQ, 12_000_000: CLK frequency in Hz.
- DEBOUNCE_MS, 20: required stable time in ms. DB_CYCLES = CLK_FREQ/1000*DEBOUNCE_MS (240_000 at defaults); DB_CYCLES ≥ 2.
- LONG_MS, 1000: hold time for a long press. LONG_CYCLES = CLK_FREQ/1000*LONG_MS (12_000_000 at defaults); LONG_CYCLES > DB_CYCLES.
- CLK  in  1  system clock, 12 MHz.
- RST  in  1  reset; synchronous, active-high.
- BTN_RAW  in  1  raw button, asynchronous, active-high (1 = pressed), bouncing.
- BTN_LEVEL  out  1  debounced button state; drives the counter's BTN.
- BTN_PRESS  out  1  one-cycle pulse on accepted press.
- BTN_RELEASE  out  1  one-cycle pulse on accepted release.
- BTN_LONG  out  1  one-cycle pulse, at most once per press, when the hold reaches LONG_CYCLES.

## Operation
- **Synchroniser:** two flip-flops on BTN_RAW. Only the second stage (sync) feeds logic.
- **Debounce counter:** width $clog2(DB_CYCLES+1). **Hold counter:** width $clog2(LONG_CYCLES+1), saturating.
- **FSM states:** IDLE, ARM_PRESS, PRESSED, ARM_RELEASE.
  - IDLE: BTN_LEVEL=0. If sync=1, go to ARM_PRESS with debounce cnt<=1.
  - ARM_PRESS:
    - If sync=0, go to IDLE with no output; the glitch is rejected.
    - Else if cnt==DB_CYCLES-1: go to PRESSED, set BTN_LEVEL<=1, pulse BTN_PRESS, clear the hold counter.
    - Else cnt<=cnt+1.
  - PRESSED:
    - The hold counter increments each cycle.
    - When hold==LONG_CYCLES-1, pulse BTN_LONG; the counter then saturates, so there is no repeat.
    - If sync=0, go to ARM_RELEASE with cnt<=1.
  - ARM_RELEASE:
    - The hold counter keeps running; BTN_LONG can fire here.
    - If sync=1, return to PRESSED. The hold counter is not cleared, and there is no output.
    - Else if cnt==DB_CYCLES-1: go to IDLE, set BTN_LEVEL<=0, pulse BTN_RELEASE.
    - Else cnt<=cnt+1.
- **Pulse outputs:** registered and high for exactly one cycle. BTN_PRESS, BTN_RELEASE and BTN_LONG are mutually exclusive in any cycle, except that BTN_LONG may coincide with BTN_RELEASE.
- **RST (priority over everything):**
  - state=IDLE, both sync FFs=0, both counters=0, all four outputs=0.
  - Mid-press reset drops BTN_LEVEL on the next edge and emits no BTN_RELEASE.
  - A button still held after RST deasserts is detected as a fresh press.

## Timing
- **Press latency:** BTN_RAW high and stable before edge 0 gives BTN_LEVEL rising and BTN_PRESS high after edge DB_CYCLES+2. This is 2 synchroniser edges plus DB_CYCLES consecutive sync=1 samples.
- **Release latency:** symmetric; BTN_LEVEL falls and BTN_RELEASE pulses DB_CYCLES+2 edges after BTN_RAW falls and stays low.
- **Glitch rejection:** a high or low glitch of fewer than DB_CYCLES sampled cycles produces no output change. The debounce count restarts from 1 on the next opposite-level run.
- **Long-press timing:** BTN_LONG is high on the cycle LONG_CYCLES edges after the BTN_PRESS cycle, provided no accepted release comes first.
- **No backpressure:** pulses are fire-and-forget, and consumers must sample every cycle.
- **Counter interaction:** the LED counter is held at 0 from the BTN_LEVEL rising edge until the cycle after its falling edge.

## Test plan
All scenarios use CLK_FREQ=1000, DEBOUNCE_MS=4 (DB_CYCLES=4) and LONG_MS=20 (LONG_CYCLES=20).
1. **Reset:** assert RST for 3 cycles with BTN_RAW=1 -> all outputs 0 throughout. After RST falls, BTN_PRESS fires 6 edges later.
2. **Clean press:** BTN_RAW goes 0→1 before edge 0 and is held for 10 cycles -> BTN_LEVEL=1 and BTN_PRESS=1 after edge 6. BTN_PRESS=0 after edge 7; no BTN_LONG.
3. **Bounce:** BTN_RAW pattern 1,1,1,0,1,1,1,0 repeating for 40 cycles -> BTN_LEVEL stays 0 and no pulses. Then hold 1 -> press after edge 6 of the stable run.
4. **Release with bounce:** while pressed, drop BTN_RAW for 2 cycles, raise it for 1, then hold it low -> no BTN_RELEASE during the bounce. BTN_RELEASE fires 6 edges after the final fall, and BTN_LEVEL=0 on the same edge.
5. **Long press:** press accepted at edge 6 and held for 40 cycles -> exactly one BTN_LONG, after edge 26. BTN_RELEASE follows the release normally.
6. **Mid-press reset:** press accepted, then RST asserted for 1 cycle -> BTN_LEVEL=0 on the next edge, no BTN_RELEASE, no BTN_LONG. The press is redetected 6 edges after RST falls if BTN_RAW is still held.
